// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register file, operand resolve with bypass/forwarding, and a one-entry issue slot feeding the ALU
module alu_operand_stage #(
    parameter int DATA_W     = 4,
    parameter int REG_ADDR_W = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0]     imm,
    input  logic                  use_imm,
    input  logic [2:0]            alu_op_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  fwd_en,
    input  logic [REG_ADDR_W-1:0] fwd_addr,
    input  logic [DATA_W-1:0]     fwd_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_a,
    output logic [DATA_W-1:0]     out_b,
    output logic [2:0]            out_alu_control,
    output logic [REG_ADDR_W-1:0] out_rd_addr
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] a_res, rt_res, b_res;
    logic              load;
    // register file; r0 is never written so it stays zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end
    // operand resolve: r0, then EX forward, then write-back bypass, then stored value
    always_comb begin
        a_res  = (rs_addr == '0) ? '0 :
                 (fwd_en && fwd_addr == rs_addr) ? fwd_data :
                 (wb_en && wb_addr == rs_addr) ? wb_data : regs[rs_addr];
        rt_res = (rt_addr == '0) ? '0 :
                 (fwd_en && fwd_addr == rt_addr) ? fwd_data :
                 (wb_en && wb_addr == rt_addr) ? wb_data : regs[rt_addr];
        b_res  = use_imm ? imm : rt_res;
        in_ready = !out_valid || out_ready;
        load     = in_valid && in_ready && !flush;
    end
    // issue slot: flush beats load, load beats drain, otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_a           <= '0;
            out_b           <= '0;
            out_alu_control <= '0;
            out_rd_addr     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid       <= 1'b1;
            out_a           <= a_res;
            out_b           <= b_res;
            out_alu_control <= alu_op_in;
            out_rd_addr     <= rd_addr_in;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed checks of reset, bypass/forwarding, r0, immediate, stall, flush and throughput
module tb_alu_operand_stage;
    logic       clk, reset, in_valid, in_ready, use_imm, wb_en, fwd_en, flush, out_valid, out_ready;
    logic [2:0] rs_addr, rt_addr, rd_addr_in, wb_addr, fwd_addr, out_rd_addr, alu_op_in, out_alu_control;
    logic [3:0] imm, wb_data, fwd_data, out_a, out_b;
    int total = 0;
    int bad = 0;

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
        .alu_op_in(alu_op_in), .rd_addr_in(rd_addr_in), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
        .out_b(out_b), .out_alu_control(out_alu_control), .out_rd_addr(out_rd_addr)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; wb_en = 0; fwd_en = 0; flush = 0; out_ready = 1; use_imm = 0;
        rs_addr = 0; rt_addr = 0; imm = 0; alu_op_in = 0; rd_addr_in = 0;
        wb_addr = 0; wb_data = 0; fwd_addr = 0; fwd_data = 0;
    endtask

    task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] op, input logic [2:0] rd);
        in_valid = 1; rs_addr = rs; rt_addr = rt; alu_op_in = op; rd_addr_in = rd;
    endtask

    task automatic test_reset();
        tick();
        total++; if ({out_valid, out_a, out_b, out_alu_control, out_rd_addr} !== 14'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_a, out_b, out_alu_control, out_rd_addr}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        reset = 0;
        tick();
        wb_en = 1; wb_addr = 3; wb_data = 5;
        tick();
        wb_en = 0; out_ready = 0;
        issue(3, 0, 3'd6, 3'd2);
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_a !== 4'd5) begin bad++; $display("FAIL pre_reset_load got v=%b a=%h exp v=1 a=5", out_valid, out_a); end
        #2 reset = 1;
        #1;
        total++; if ({out_valid, out_a, out_b, out_alu_control, out_rd_addr} !== 14'd0) begin bad++; $display("FAIL midstall_reset got=%h exp=0", {out_valid, out_a, out_b, out_alu_control, out_rd_addr}); end
        tick();
        reset = 0;
        out_ready = 1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        issue(3, 3, 3'd1, 3'd1);
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_a !== 4'd0 || out_b !== 4'd0) begin bad++; $display("FAIL reg_cleared got v=%b a=%h b=%h exp v=1 a=0 b=0", out_valid, out_a, out_b); end
        tick();
    endtask

    task automatic test_wb();
        wb_en = 1; wb_addr = 3; wb_data = 5;
        tick();
        wb_en = 0;
        issue(3, 0, 3'd0, 3'd5);
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_a !== 4'd5 || out_b !== 4'd0 || out_alu_control !== 3'd0 || out_rd_addr !== 3'd5) begin bad++; $display("FAIL wb_issue got v=%b a=%h b=%h op=%h rd=%h exp v=1 a=5 b=0 op=0 rd=5", out_valid, out_a, out_b, out_alu_control, out_rd_addr); end
        tick();
        total++; if (out_valid !== 1'b0 || out_a !== 4'd5) begin bad++; $display("FAIL wb_drain got v=%b a=%h exp v=0 a=5", out_valid, out_a); end
    endtask

    task automatic test_bypass();
        wb_en = 1; wb_addr = 2; wb_data = 9;
        issue(2, 0, 3'd5, 3'd4);
        tick();
        total++; if (out_a !== 4'd9 || out_alu_control !== 3'd5 || out_rd_addr !== 3'd4) begin bad++; $display("FAIL wb_bypass got a=%h op=%h rd=%h exp a=9 op=5 rd=4", out_a, out_alu_control, out_rd_addr); end
        fwd_en = 1; fwd_addr = 2; fwd_data = 4;
        issue(2, 2, 3'd2, 3'd1);
        tick();
        total++; if (out_a !== 4'd4 || out_b !== 4'd4) begin bad++; $display("FAIL fwd_wins got a=%h b=%h exp a=4 b=4", out_a, out_b); end
        wb_en = 0; fwd_en = 0;
        issue(2, 3, 3'd3, 3'd1);
        tick();
        in_valid = 0;
        total++; if (out_a !== 4'd9 || out_b !== 4'd5) begin bad++; $display("FAIL stored_regs got a=%h b=%h exp a=9 b=5", out_a, out_b); end
        tick();
    endtask

    task automatic test_r0_imm();
        wb_en = 1; wb_addr = 0; wb_data = 7;
        tick();
        wb_en = 0;
        fwd_en = 1; fwd_addr = 0; fwd_data = 7;
        issue(0, 0, 3'd1, 3'd0);
        tick();
        total++; if (out_a !== 4'd0 || out_b !== 4'd0) begin bad++; $display("FAIL r0_zero got a=%h b=%h exp a=0 b=0", out_a, out_b); end
        fwd_addr = 3; fwd_data = 1;
        use_imm = 1; imm = 6;
        issue(2, 3, 3'd7, 3'd3);
        tick();
        in_valid = 0; use_imm = 0; fwd_en = 0;
        total++; if (out_a !== 4'd9 || out_b !== 4'd6 || out_alu_control !== 3'd7) begin bad++; $display("FAIL imm_b got a=%h b=%h op=%h exp a=9 b=6 op=7", out_a, out_b, out_alu_control); end
        tick();
    endtask

    task automatic test_stall();
        out_ready = 0;
        issue(3, 0, 3'd1, 3'd1);
        tick();
        issue(2, 0, 3'd2, 3'd2);
        total++; if (out_valid !== 1'b1 || out_a !== 4'd5) begin bad++; $display("FAIL stall_first got v=%b a=%h exp v=1 a=5", out_valid, out_a); end
        for (int i = 0; i < 3; i++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || out_a !== 4'd5 || out_alu_control !== 3'd1) begin bad++; $display("FAIL stall_hold[%0d] got v=%b a=%h op=%h exp v=1 a=5 op=1", i, out_valid, out_a, out_alu_control); end
        end
        out_ready = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_a !== 4'd9 || out_alu_control !== 3'd2) begin bad++; $display("FAIL stall_next got v=%b a=%h op=%h exp v=1 a=9 op=2", out_valid, out_a, out_alu_control); end
        tick();
        total++; if (out_valid !== 1'b0 || out_a !== 4'd9) begin bad++; $display("FAIL stall_drain got v=%b a=%h exp v=0 a=9", out_valid, out_a); end
    endtask

    task automatic test_flush();
        out_ready = 0;
        issue(3, 0, 3'd4, 3'd1);
        tick();
        out_ready = 1;
        flush = 1;
        wb_en = 1; wb_addr = 4; wb_data = 4'hC;
        issue(2, 0, 3'd6, 3'd6);
        tick();
        flush = 0; wb_en = 0;
        in_valid = 0;
        total++; if (out_valid !== 1'b0 || out_a !== 4'd5 || out_alu_control !== 3'd4) begin bad++; $display("FAIL flush_slot got v=%b a=%h op=%h exp v=0 a=5 op=4", out_valid, out_a, out_alu_control); end
        issue(4, 0, 3'd0, 3'd0);
        tick();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_a !== 4'hC) begin bad++; $display("FAIL flush_wb_kept got v=%b a=%h exp v=1 a=c", out_valid, out_a); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] rs_q [4];
        logic [3:0] exp_q [4];
        rs_q = '{3'd2, 3'd3, 3'd4, 3'd7};
        exp_q = '{4'd9, 4'd5, 4'hC, 4'hF};
        wb_en = 1; wb_addr = 7; wb_data = 4'hF;
        tick();
        wb_en = 0;
        for (int i = 0; i < 4; i++) begin
            issue(rs_q[i], 0, 3'(i), 3'(i));
            tick();
            total++; if (out_valid !== 1'b1 || out_a !== exp_q[i] || out_alu_control !== 3'(i)) begin bad++; $display("FAIL b2b[%0d] got v=%b a=%h op=%h exp v=1 a=%h op=%h", i, out_valid, out_a, out_alu_control, exp_q[i], 3'(i)); end
        end
        in_valid = 0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got v=%b exp v=0", out_valid); end
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_wb();
        test_bypass();
        test_r0_imm();
        test_stall();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
